// File: rtl/fvec_pair_source_if.sv
// One operand stream channel: a PARALLELISM-wide beat with valid/ready/tlast.
// The producer uses the master modport and the consuming adder uses the slave modport.
interface fvec_pair_source_if #(
  parameter int WIDTH = 96
);
  logic [WIDTH-1:0] data;
  logic             valid;
  logic             ready;
  logic             tlast;

  modport master (output data, output valid, output tlast, input ready);
  modport slave  (input data, input valid, input tlast, output ready);
endinterface

// File: rtl/fvec_pair_source.sv
// Operand producer for the vector FP adder: streams num_beats words from memories A and B
// as two aligned valid/ready/tlast channels, with credit-based issue into per-channel FIFOs.
module fvec_pair_source #(
  parameter int PARALLELISM = 3,
  parameter int BIT_SIZE    = 32,
  parameter int ADDR_WIDTH  = 16,
  parameter int LEN_WIDTH   = 16,
  parameter int MEM_LATENCY = 1,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [ADDR_WIDTH-1:0]           base_a,
  input  logic [ADDR_WIDTH-1:0]           base_b,
  input  logic [LEN_WIDTH-1:0]            num_beats,
  output logic                            busy,
  output logic                            done,
  output logic                            rd_en_a,
  output logic [ADDR_WIDTH-1:0]           rd_addr_a,
  input  logic [BIT_SIZE*PARALLELISM-1:0] rd_data_a,
  output logic                            rd_en_b,
  output logic [ADDR_WIDTH-1:0]           rd_addr_b,
  input  logic [BIT_SIZE*PARALLELISM-1:0] rd_data_b,
  fvec_pair_source_if.master              a,
  fvec_pair_source_if.master              b
);

  localparam int W  = BIT_SIZE * PARALLELISM;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [LEN_WIDTH-1:0] LEN_ONE = 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  base_a_q, base_a_d, base_b_q, base_b_d;
  logic [LEN_WIDTH-1:0]   num_q, num_d, issued_q, issued_d;
  logic [LEN_WIDTH-1:0]   hs_a_q, hs_a_d, hs_b_q, hs_b_d;
  logic [CW-1:0]          inflight_q, inflight_d;
  logic [MEM_LATENCY-1:0] vpipe_q, vpipe_d, lpipe_q, lpipe_d;

  logic [W:0]    fifo_q   [2][FIFO_DEPTH];
  logic [W:0]    fifo_d   [2][FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q [2];
  logic [PW-1:0] wr_ptr_d [2];
  logic [PW-1:0] rd_ptr_q [2];
  logic [PW-1:0] rd_ptr_d [2];
  logic [CW-1:0] cnt_q    [2];
  logic [CW-1:0] cnt_d    [2];

  logic          issue, arrive, credit_ok;
  logic [1:0]    pop, ready, not_empty;
  logic [W-1:0]  rd_data  [2];
  logic [W:0]    head     [2];

  assign rd_data[0] = rd_data_a;
  assign rd_data[1] = rd_data_b;
  assign ready      = {b.ready, a.ready};
  assign head[0]    = fifo_q[0][rd_ptr_q[0]];
  assign head[1]    = fifo_q[1][rd_ptr_q[1]];
  assign not_empty  = {(cnt_q[1] != '0), (cnt_q[0] != '0)};

  // Credits cover words already buffered plus words still in the memory pipe.
  always_comb begin
    credit_ok = 1'b1;
    for (int c = 0; c < 2; c++) begin
      if ((int'(cnt_q[c]) + int'(inflight_q)) >= FIFO_DEPTH) credit_ok = 1'b0;
    end
    issue  = (state_q == S_RUN) && (issued_q != num_q) && credit_ok;
    arrive = vpipe_q[MEM_LATENCY-1];
    pop    = not_empty & ready;
  end

  always_comb begin
    vpipe_d    = vpipe_q;
    lpipe_d    = lpipe_q;
    vpipe_d[0] = issue;
    lpipe_d[0] = issue && (issued_q == num_q - LEN_ONE);
    for (int i = 1; i < MEM_LATENCY; i++) begin
      vpipe_d[i] = vpipe_q[i-1];
      lpipe_d[i] = lpipe_q[i-1];
    end
    inflight_d = inflight_q + CW'(issue) - CW'(arrive);
    fifo_d     = fifo_q;
    for (int c = 0; c < 2; c++) begin
      wr_ptr_d[c] = wr_ptr_q[c];
      rd_ptr_d[c] = rd_ptr_q[c];
      cnt_d[c]    = cnt_q[c] + CW'(arrive) - CW'(pop[c]);
      if (arrive) begin
        fifo_d[c][wr_ptr_q[c]] = {lpipe_q[MEM_LATENCY-1], rd_data[c]};
        wr_ptr_d[c]            = wr_ptr_q[c] + PW'(1);
      end
      if (pop[c]) rd_ptr_d[c] = rd_ptr_q[c] + PW'(1);
    end
  end

  always_comb begin
    state_d  = state_q;
    base_a_d = base_a_q;
    base_b_d = base_b_q;
    num_d    = num_q;
    issued_d = issued_q + LEN_WIDTH'(issue);
    hs_a_d   = hs_a_q + LEN_WIDTH'(pop[0]);
    hs_b_d   = hs_b_q + LEN_WIDTH'(pop[1]);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_a_d = base_a;
          base_b_d = base_b;
          num_d    = num_beats;
          issued_d = '0;
          hs_a_d   = '0;
          hs_b_d   = '0;
          state_d  = (num_beats == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN:   if (issued_q == num_q) state_d = S_DRAIN;
      S_DRAIN: if ((hs_a_q == num_q) && (hs_b_q == num_q)) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      base_a_q   <= '0;
      base_b_q   <= '0;
      num_q      <= '0;
      issued_q   <= '0;
      hs_a_q     <= '0;
      hs_b_q     <= '0;
      inflight_q <= '0;
      vpipe_q    <= '0;
      lpipe_q    <= '0;
      for (int c = 0; c < 2; c++) begin
        wr_ptr_q[c] <= '0;
        rd_ptr_q[c] <= '0;
        cnt_q[c]    <= '0;
      end
    end else begin
      state_q    <= state_d;
      base_a_q   <= base_a_d;
      base_b_q   <= base_b_d;
      num_q      <= num_d;
      issued_q   <= issued_d;
      hs_a_q     <= hs_a_d;
      hs_b_q     <= hs_b_d;
      inflight_q <= inflight_d;
      vpipe_q    <= vpipe_d;
      lpipe_q    <= lpipe_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
    end
  end

  // Storage needs no reset: outputs are gated by the FIFO counts, which are reset.
  always_ff @(posedge clk) begin
    fifo_q <= fifo_d;
  end

  assign busy      = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done      = (state_q == S_DONE);
  assign rd_en_a   = issue;
  assign rd_en_b   = issue;
  assign rd_addr_a = (state_q == S_RUN) ? base_a_q + ADDR_WIDTH'(issued_q) : '0;
  assign rd_addr_b = (state_q == S_RUN) ? base_b_q + ADDR_WIDTH'(issued_q) : '0;
  assign a.valid   = not_empty[0];
  assign a.data    = not_empty[0] ? head[0][W-1:0] : '0;
  assign a.tlast   = not_empty[0] && head[0][W];
  assign b.valid   = not_empty[1];
  assign b.data    = not_empty[1] ? head[1][W-1:0] : '0;
  assign b.tlast   = not_empty[1] && head[1][W];

endmodule
